// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: accepts a parallel word over valid/ready and shifts it out
// MSB-first, optionally repeated back-to-back. Keeps a saturating count of
// overlapping "101" occurrences seen on the emitted serial stream.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_repeat,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [3:0]       rep;
    logic [3:0]       rep_next;
    logic             out_bit_next;
    logic             done_next;
    logic [1:0]       hist;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Next-state logic: accept in IDLE, walk the bit index down in SHIFT,
    // reload the index for each extra repetition, finish after the last bit.
    always_comb begin
        state_next = state;
        word_next  = word;
        idx_next   = idx;
        rep_next   = rep;
        done_next  = 1'b0;
        in_ready   = (state == IDLE);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    word_next  = in_data;
                    rep_next   = in_repeat;
                    idx_next   = IDX_LAST;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (idx == '0) begin
                    if (rep != 4'd0) begin
                        rep_next = rep - 4'd1;
                        idx_next = IDX_LAST;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    idx_next = idx - IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // The bit presented next cycle is looked up ahead of time so that the
        // serial outputs come straight from flops.
        out_bit_next = (state_next == SHIFT) ? word_next[idx_next] : 1'b0;
    end

    // State, datapath and registered serial outputs; reset abandons any word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            word      <= '0;
            idx       <= '0;
            rep       <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            word      <= word_next;
            idx       <= idx_next;
            rep       <= rep_next;
            out_bit   <= out_bit_next;
            out_valid <= (state_next == SHIFT);
            busy      <= (state_next == SHIFT);
            done      <= done_next;
        end
    end

    // Pattern tracker: history of the last two valid bits survives idle gaps,
    // so a "101" straddling two words still counts; clear beats a match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist      <= 2'b00;
            match_cnt <= '0;
        end else if (clear) begin
            hist      <= 2'b00;
            match_cnt <= '0;
        end else if (out_valid) begin
            hist <= {hist[0], out_bit};
            if (hist == 2'b10 && out_bit) begin
                match_cnt <= sat_inc(match_cnt);
            end
        end
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-stream generator that feeds the team's sequence detectors (101 Moore/Mealy). It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, optionally repeated. It also keeps a running count of overlapping "101" occurrences in the emitted stream, so a bench can compare that count against detector pulses. It sits between a stimulus source (CPU register or test sequencer) and the detector's serial input.

## Interface
- WIDTH, 8, bits per word; range 2..32
- CNT_W, 8, width of match counter
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; all state to reset values
- clear  input  1  synchronous; zeroes match_cnt and bit history; does not affect shifting
- in_valid  input  1  word offered
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  word to transmit, MSB first
- in_repeat  input  4  extra repetitions; word sent in_repeat+1 times back-to-back
- out_bit  output  1  serial data; 0 whenever out_valid=0
- out_valid  output  1  out_bit carries a stream bit this cycle
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse after the final bit of a transaction
- match_cnt  output  CNT_W  overlapping "101" count over valid bits since reset/clear, saturating

## Operation
- States: IDLE, SHIFT.
- IDLE: in_ready=1, out_valid=0, busy=0. Accept when in_valid&in_ready: latch in_data into the shift register, in_repeat into the repeat counter, and load bit index WIDTH-1. Go to SHIFT.
- SHIFT: in_ready=0, busy=1, out_valid=1, out_bit = word[index].
  - Index decrements each cycle.
  - At index 0 with repeat counter >0: decrement the repeat counter, reload index to WIDTH-1, and reuse the latched word. No gap between repetitions.
  - At index 0 with repeat counter =0: go to IDLE.
- in_valid during SHIFT is ignored; no word is captured and no error is flagged.
- History: 2-bit register of the last two valid bits, reset to 00.
  - Updated only on cycles with out_valid=1.
  - Persists across words and idle gaps, so a pattern spanning two transactions counts.
- Match: on a valid cycle where history=10 and out_bit=1, match_cnt increments by 1. It saturates at 2^CNT_W-1 and does not wrap.
- clear and a match in the same cycle: clear wins, so match_cnt becomes 0 and history becomes 00.
- Reset values: state IDLE, in_ready 1 (combinational from state), out_bit 0, out_valid 0, busy 0, done 0, match_cnt 0, history 00.
- Reset mid-SHIFT: immediately abandons the word. Outputs take reset values asynchronously, and no done pulse is produced.

## Timing
- Handshake accepted on edge T. The first bit appears on out_bit/out_valid in cycle T+1, i.e. after edge T.
- Total valid bits N = WIDTH*(in_repeat+1), occupying cycles T+1..T+N. out_valid drops in cycle T+N+1.
- done is high in cycle T+N+1 only. in_ready is high in the same cycle, so the next accept can occur at edge T+N+1 and its first bit appears in T+N+2.
- The minimum idle gap between transactions is therefore one cycle.
- out_bit, out_valid, busy, and done are registered, with no combinational path from inputs.
- in_ready is decoded from state.
- match_cnt is registered: a match completed by the valid bit in cycle k is visible in cycle k+1.

## Test plan
- in_data=8'hA5 (10100101), repeat 0 -> out_bit 1,0,1,0,0,1,0,1 in cycles T+1..T+8. done pulses at T+9 and match_cnt=2.
- in_data=8'hAA, repeat 1 -> 16 bits alternating 1,0 with no gap at the word boundary. busy is high for 16 cycles and match_cnt=7.
- Cross-word stream: send 8'h01, then 8'h40 accepted in the done cycle. The idle gap is ignored by history, so the trailing 1 plus the leading 0,1 gives match_cnt=1.
- Drive in_valid=1 with 8'hFF during SHIFT of 8'h00 -> the second word is not accepted until done. out_bit stays 0 for all 8 bits and match_cnt=0.
- CNT_W=2, stream 8'hAA repeat 1 -> match_cnt saturates at 3 and holds. Then pulse clear -> match_cnt=0 the next cycle while shifting continues unaffected.
- Assert reset at bit 3 of a transfer -> out_valid=0, busy=0, in_ready=1, and match_cnt=0 immediately, with no done pulse. A new accept after release transmits correctly from the MSB.
